// File: rtl/cb_pkg.sv
// rtl/cb_pkg.sv - shared constants and round-robin helper for the crossbar
package cb_pkg;

    localparam int CB_NPORT = 5;
    localparam int CB_DATAW = 64;
    localparam int CB_VCHW  = 1;
    localparam int CB_PORTW = 3;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cb_rr_lock_if.sv
// rtl/cb_rr_lock_if.sv - crossbar flit/request/grant bundle between VC buffers and link registers
interface cb_rr_lock_if
    import cb_pkg::*;
#(
    parameter int NPORT = CB_NPORT,
    parameter int DATAW = CB_DATAW,
    parameter int VCHW  = CB_VCHW,
    parameter int PORTW = CB_PORTW
);
    logic [NPORT*DATAW-1:0] idata;
    logic [NPORT-1:0]       ivalid;
    logic [NPORT-1:0]       itail;
    logic [NPORT*VCHW-1:0]  ivch;
    logic [NPORT*PORTW-1:0] port;
    logic [NPORT-1:0]       req;
    logic [NPORT*NPORT-1:0] grt;
    logic [NPORT*DATAW-1:0] odata;
    logic [NPORT-1:0]       ovalid;
    logic [NPORT-1:0]       otail;
    logic [NPORT*VCHW-1:0]  ovch;

    modport master (
        output idata, ivalid, itail, ivch, port, req,
        input  grt, odata, ovalid, otail, ovch
    );

    modport slave (
        input  idata, ivalid, itail, ivch, port, req,
        output grt, odata, ovalid, otail, ovch
    );
endinterface

// File: rtl/cb_rr_arb.sv
// rtl/cb_rr_arb.sv - per-output round-robin arbiter holding the grant from head to tail flit
module cb_rr_arb
    import cb_pkg::*;
#(
    parameter int NPORT = CB_NPORT,
    parameter int PORTW = CB_PORTW
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [NPORT-1:0] i_req,
    input  logic [NPORT-1:0] i_ivalid,
    input  logic [NPORT-1:0] i_itail,
    output logic             o_lock,
    output logic [PORTW-1:0] o_owner,
    output logic [NPORT-1:0] o_gcol
);
    logic             r_lock;
    logic [PORTW-1:0] r_owner;
    logic [PORTW-1:0] r_ptr;
    logic             w_free;
    logic             w_found;
    logic [PORTW-1:0] w_pick;
    logic [PORTW-1:0] w_idx;
    int               w_pos;

    // The edge that takes the owner's tail also re-arbitrates, so packets run back to back.
    assign w_free = !r_lock || (i_ivalid[r_owner] && i_itail[r_owner]);

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_pos   = 0;
        w_idx   = '0;
        for (int k = 0; k < NPORT; k++) begin
            w_pos = int'(r_ptr) + k;
            if (w_pos >= NPORT) w_pos = w_pos - NPORT;
            w_idx = PORTW'(w_pos);
            if (!w_found && i_req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_lock  <= 1'b0;
            r_owner <= '0;
            r_ptr   <= '0;
        end else if (w_free) begin
            r_lock <= w_found;
            if (w_found) begin
                r_owner <= w_pick;
                r_ptr   <= PORTW'(rr_next(int'(w_pick), NPORT));
            end
        end
    end

    always_comb begin
        o_gcol = '0;
        if (r_lock) o_gcol[r_owner] = 1'b1;
    end

    assign o_lock  = r_lock;
    assign o_owner = r_owner;
endmodule

// File: rtl/cb_rr_lock.sv
// rtl/cb_rr_lock.sv - NPORT x NPORT crossbar with round-robin, wormhole locking and registered outputs
module cb_rr_lock
    import cb_pkg::*;
#(
    parameter int NPORT = CB_NPORT,
    parameter int DATAW = CB_DATAW,
    parameter int VCHW  = CB_VCHW,
    parameter int PORTW = CB_PORTW
) (
    input logic         clk,
    input logic         rst_,
    cb_rr_lock_if.slave bus
);
    logic [DATAW-1:0] w_idata [NPORT];
    logic [VCHW-1:0]  w_ivch  [NPORT];
    logic [PORTW-1:0] w_port  [NPORT];
    logic [NPORT-1:0] w_gcol  [NPORT];
    logic [PORTW-1:0] w_owner [NPORT];
    logic [NPORT-1:0] w_lock;
    logic [NPORT-1:0] w_owned;

    for (genvar gi = 0; gi < NPORT; gi++) begin : g_in
        assign w_idata[gi] = bus.idata[gi*DATAW +: DATAW];
        assign w_ivch[gi]  = bus.ivch[gi*VCHW +: VCHW];
        assign w_port[gi]  = bus.port[gi*PORTW +: PORTW];
    end

    // An input already holding an output may not request another one.
    always_comb begin
        w_owned = '0;
        for (int o = 0; o < NPORT; o++) begin
            for (int i = 0; i < NPORT; i++) begin
                w_owned[i] = w_owned[i] | w_gcol[o][i];
            end
        end
    end

    for (genvar go = 0; go < NPORT; go++) begin : g_out
        logic [NPORT-1:0] w_req;
        logic [DATAW-1:0] r_odata;
        logic             r_ovalid;
        logic             r_otail;
        logic [VCHW-1:0]  r_ovch;

        for (genvar gi = 0; gi < NPORT; gi++) begin : g_col
            assign w_req[gi] = bus.req[gi] && (w_port[gi] == PORTW'(go)) && !w_owned[gi];
            assign bus.grt[gi*NPORT + go] = w_gcol[go][gi];
        end

        cb_rr_arb #(
            .NPORT (NPORT),
            .PORTW (PORTW)
        ) u_arb (
            .clk      (clk),
            .rst_     (rst_),
            .i_req    (w_req),
            .i_ivalid (bus.ivalid),
            .i_itail  (bus.itail),
            .o_lock   (w_lock[go]),
            .o_owner  (w_owner[go]),
            .o_gcol   (w_gcol[go])
        );

        // Mux follows the locked owner, so flits from any other input never reach this output.
        always_ff @(posedge clk or negedge rst_) begin
            if (!rst_) begin
                r_odata  <= '0;
                r_ovalid <= 1'b0;
                r_otail  <= 1'b0;
                r_ovch   <= '0;
            end else begin
                r_ovalid <= w_lock[go] && bus.ivalid[w_owner[go]];
                if (w_lock[go]) begin
                    r_odata <= w_idata[w_owner[go]];
                    r_otail <= bus.itail[w_owner[go]];
                    r_ovch  <= w_ivch[w_owner[go]];
                end
            end
        end

        assign bus.odata[go*DATAW +: DATAW] = r_odata;
        assign bus.ovalid[go]               = r_ovalid;
        assign bus.otail[go]                = r_otail;
        assign bus.ovch[go*VCHW +: VCHW]    = r_ovch;
    end
endmodule
